// File: rtl/nios_system_timer_sched_if.sv
// rtl/nios_system_timer_sched_if.sv - Avalon-MM link between the scheduler and the interval timer
interface nios_system_timer_sched_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/nios_system_timer_sched.sv
// rtl/nios_system_timer_sched.sv - round-robin scheduler sharing one interval timer among N_REQ one-shot requesters
module nios_system_timer_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    period,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [IDW-1:0]         active_id,
  nios_system_timer_sched_if.master tmr
);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_WAIT, S_STOP, S_CLR, S_DONE
  } state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [15:0]    period_hi;
  logic           aborted;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW:0]   cand;
  logic [31:0]    pick_period;
  logic [31:0]    pick_len;
  logic [IDW:0]   owner_inc;
  logic [IDW-1:0] ptr_next;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    pick_period = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_idx == IDW'(i)) pick_period = period[32*i +: 32];
  end

  assign pick_len  = (pick_period == 32'd0) ? 32'd1 : pick_period;
  assign owner_inc = {1'b0, active_id} + (IDW+1)'(1);
  assign ptr_next  = (owner_inc >= NREQ_W) ? '0 : owner_inc[IDW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      active_id          <= '0;
      period_hi          <= '0;
      aborted            <= 1'b0;
      done               <= '0;
      busy               <= 1'b0;
      tmr.tmr_chipselect <= 1'b0;
      tmr.tmr_write_n    <= 1'b1;
      tmr.tmr_address    <= '0;
      tmr.tmr_writedata  <= '0;
    end else begin
      tmr.tmr_chipselect <= 1'b0;
      tmr.tmr_write_n    <= 1'b1;
      done               <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_GRANT;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (pick_found) begin
            active_id          <= pick_idx;
            period_hi          <= pick_len[31:16];
            aborted            <= 1'b0;
            tmr.tmr_chipselect <= 1'b1;
            tmr.tmr_write_n    <= 1'b0;
            tmr.tmr_address    <= 3'd2;
            tmr.tmr_writedata  <= pick_len[15:0];
            state              <= S_WR_PL;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WR_PL: begin
          tmr.tmr_chipselect <= 1'b1;
          tmr.tmr_write_n    <= 1'b0;
          tmr.tmr_address    <= 3'd3;
          tmr.tmr_writedata  <= period_hi;
          state              <= S_WR_PH;
        end
        S_WR_PH: state <= S_GAP;
        S_GAP: begin
          tmr.tmr_chipselect <= 1'b1;
          tmr.tmr_write_n    <= 1'b0;
          tmr.tmr_address    <= 3'd1;
          tmr.tmr_writedata  <= 16'h0005;
          state              <= S_WR_CTL;
        end
        S_WR_CTL: state <= S_WAIT;
        // The IRQ takes priority over a simultaneous request drop.
        S_WAIT: begin
          if (tmr.tmr_irq) begin
            tmr.tmr_chipselect <= 1'b1;
            tmr.tmr_write_n    <= 1'b0;
            tmr.tmr_address    <= 3'd0;
            tmr.tmr_writedata  <= 16'h0000;
            state              <= S_CLR;
          end else if (!req[active_id]) begin
            tmr.tmr_chipselect <= 1'b1;
            tmr.tmr_write_n    <= 1'b0;
            tmr.tmr_address    <= 3'd1;
            tmr.tmr_writedata  <= 16'h0008;
            aborted            <= 1'b1;
            state              <= S_STOP;
          end
        end
        S_STOP: begin
          tmr.tmr_chipselect <= 1'b1;
          tmr.tmr_write_n    <= 1'b0;
          tmr.tmr_address    <= 3'd0;
          tmr.tmr_writedata  <= 16'h0000;
          state              <= S_CLR;
        end
        S_CLR: begin
          rr_ptr <= ptr_next;
          if (aborted) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            done[active_id] <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_timer_sched.sv
// tb/tb_nios_system_timer_sched.sv - directed bench with a cycle-plan reference model and a behavioural timer
module tb_nios_system_timer_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [32*N-1:0] period = '0;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     active_id;

  nios_system_timer_sched_if tmr();

  nios_system_timer_sched #(.N_REQ(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .period    (period),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .tmr       (tmr.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit check_en = 0;
  bit auto_irq = 1;
  int irq_cyc = 0;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for one cycle; the model queues whole sequences of these.
  typedef struct { bit busy; bit cs; bit [2:0] addr; bit [15:0] data; bit [3:0] done; bit [1:0] id; } rec_t;
  typedef struct { int c; int a; int d; } wr_t;

  rec_t plan[$];
  rec_t exp_r;
  wr_t  wlog[$];
  int   dcyc[$];
  int   didx[$];

  localparam int M_IDLE = 0, M_GRANT = 1, M_SETUP = 2, M_WAIT = 3, M_END = 4;
  int m_mode = M_IDLE, m_ptr = 0, m_owner = 0;
  bit [31:0] m_len;

  function automatic rec_t mk(bit b, bit cs, int a, int d, int dn, int id);
    rec_t r;
    r.busy = b; r.cs = cs; r.addr = 3'(a); r.data = 16'(d); r.done = 4'(dn); r.id = 2'(id);
    return r;
  endfunction

  initial begin
    exp_r = mk(0, 0, 0, 0, 0, 0);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        plan.delete();
        m_mode = M_IDLE; m_ptr = 0; m_owner = 0;
        exp_r = mk(0, 0, 0, 0, 0, 0);
      end else begin
        if (plan.size() == 0) begin
          case (m_mode)
            M_IDLE: begin
              if (req != 0) begin plan.push_back(mk(1, 0, 0, 0, 0, m_owner)); m_mode = M_GRANT; end
              else plan.push_back(mk(0, 0, 0, 0, 0, m_owner));
            end
            M_GRANT: begin
              int w;
              w = -1;
              for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
              if (w < 0) begin
                plan.push_back(mk(0, 0, 0, 0, 0, m_owner)); m_mode = M_IDLE;
              end else begin
                m_owner = w;
                m_len = period[32*w +: 32];
                if (m_len == 0) m_len = 1;
                plan.push_back(mk(1, 1, 2, int'(m_len[15:0]), 0, w));
                plan.push_back(mk(1, 1, 3, int'(m_len[31:16]), 0, w));
                plan.push_back(mk(1, 0, 0, 0, 0, w));
                plan.push_back(mk(1, 1, 1, 5, 0, w));
                m_mode = M_SETUP;
              end
            end
            M_SETUP: begin plan.push_back(mk(1, 0, 0, 0, 0, m_owner)); m_mode = M_WAIT; end
            M_WAIT: begin
              if (tmr.tmr_irq) begin
                plan.push_back(mk(1, 1, 0, 0, 0, m_owner));
                plan.push_back(mk(1, 0, 0, 0, 1 << m_owner, m_owner));
                m_ptr = (m_owner + 1) % N; m_mode = M_END;
              end else if (!req[m_owner]) begin
                plan.push_back(mk(1, 1, 1, 8, 0, m_owner));
                plan.push_back(mk(1, 1, 0, 0, 0, m_owner));
                m_ptr = (m_owner + 1) % N; m_mode = M_END;
              end else plan.push_back(mk(1, 0, 0, 0, 0, m_owner));
            end
            default: begin plan.push_back(mk(0, 0, 0, 0, 0, m_owner)); m_mode = M_IDLE; end
          endcase
        end
        exp_r = plan.pop_front();
      end
    end
  end

  // Per-cycle compare, bus/done logging and the timer slave, all in one ordered process.
  int t_cnt = 0;
  bit t_run = 0;
  bit [15:0] t_lo = 0, t_hi = 0;
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("busy", busy, exp_r.busy);
      chk("chipselect", tmr.tmr_chipselect, exp_r.cs);
      chk("write_n", tmr.tmr_write_n, !exp_r.cs);
      chk("done", done, exp_r.done);
      if (exp_r.cs) begin
        chk("address", tmr.tmr_address, exp_r.addr);
        chk("writedata", tmr.tmr_writedata, exp_r.data);
      end
      if (exp_r.busy) chk("active_id", active_id, exp_r.id);
    end
    if (done != 0) for (int i = 0; i < N; i++) if (done[i]) begin dcyc.push_back(cyc); didx.push_back(i); end
    if (reset) begin
      t_run = 0; tmr.tmr_irq = 1'b0;
    end else if (tmr.tmr_chipselect && !tmr.tmr_write_n) begin
      wr_t w;
      w.c = cyc; w.a = int'(tmr.tmr_address); w.d = int'(tmr.tmr_writedata);
      wlog.push_back(w);
      case (tmr.tmr_address)
        3'd2: t_lo = tmr.tmr_writedata;
        3'd3: t_hi = tmr.tmr_writedata;
        3'd1: if (tmr.tmr_writedata[2]) begin
                t_run = 1; t_cnt = ((({t_hi, t_lo} == 0) ? 1 : int'({t_hi, t_lo}))) + 2;
              end else if (tmr.tmr_writedata[3]) t_run = 0;
        3'd0: tmr.tmr_irq = 1'b0;
        default: ;
      endcase
    end else if (t_run && auto_irq) begin
      t_cnt--;
      if (t_cnt == 0) begin tmr.tmr_irq = 1'b1; irq_cyc = cyc; t_run = 0; end
    end
  end

  function automatic int wl_a(int i); return (i < wlog.size()) ? wlog[i].a : -1; endfunction
  function automatic int wl_d(int i); return (i < wlog.size()) ? wlog[i].d : -1; endfunction
  function automatic int wl_c(int i); return (i < wlog.size()) ? wlog[i].c : -1; endfunction

  task automatic step(); @(negedge clk); #1; endtask

  task automatic wait_done(input int idx, input int budget, output int dc);
    dc = -1;
    for (int n = 0; n < budget; n++) begin
      step();
      if (done[idx]) begin dc = cyc; return; end
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_ctl(input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (tmr.tmr_chipselect && !tmr.tmr_write_n && tmr.tmr_address == 3'd1 && tmr.tmr_writedata == 16'h5) return;
    end
    chk("wait_ctl_timeout", 0, 1);
  endtask

  task automatic do_reset();
    step(); reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  function automatic void clear_logs(); wlog.delete(); dcyc.delete(); didx.delete(); endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, stop_i;
    int rr_exp[4];
    tmr.tmr_irq = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_cs", tmr.tmr_chipselect, 0);
    chk("reset_write_n", tmr.tmr_write_n, 1);
    reset = 1'b0;
    check_en = 1;
    step();

    // Single request, period 100
    clear_logs();
    period[31:0] = 32'd100; req = 4'b0001; t = cyc;
    wait_done(0, 300, d);
    req = 4'b0000;
    chk("t1_pl_addr", wl_a(0), 2);  chk("t1_pl_data", wl_d(0), 100); chk("t1_pl_cyc", wl_c(0) - t, 2);
    chk("t1_ph_addr", wl_a(1), 3);  chk("t1_ph_data", wl_d(1), 0);   chk("t1_ph_cyc", wl_c(1) - t, 3);
    chk("t1_ctl_addr", wl_a(2), 1); chk("t1_ctl_data", wl_d(2), 5);  chk("t1_ctl_cyc", wl_c(2) - t, 5);
    chk("t1_clr_addr", wl_a(3), 0); chk("t1_clr_cyc", wl_c(3) - t, 108);
    chk("t1_done_cyc", d - t, 109);
    chk("t1_irq_to_done", d - irq_cyc, 2);
    repeat (3) step();
    chk("t1_busy_after", busy, 0);

    // Round-robin from pointer 0 with 1011 held
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) period[32*i +: 32] = 32'd20;
    req = 4'b1011;
    rr_exp = '{0, 1, 3, 0};
    for (int g = 0; g < 4; g++) begin
      wait_done(rr_exp[g], 200, d);
      if (g == 3) req = 4'b0000;
    end
    chk("rr_count", didx.size(), 4);
    for (int g = 0; g < 4; g++) chk($sformatf("rr_order%0d", g), (g < didx.size()) ? didx[g] : -1, rr_exp[g]);

    // Large period, IRQ raised by hand
    clear_logs();
    auto_irq = 0;
    period[95:64] = 32'h0001_86A0; req = 4'b0100;
    wait_ctl(50);
    repeat (20) step();
    chk("t3_no_early_done", didx.size(), 0);
    tmr.tmr_irq = 1'b1; irq_cyc = cyc;
    wait_done(2, 20, d);
    req = 4'b0000;
    auto_irq = 1;
    chk("t3_pl_data", wl_d(0), 32'h86A0);
    chk("t3_ph_addr", wl_a(1), 3);
    chk("t3_ph_data", wl_d(1), 1);
    chk("t3_irq_to_done", d - irq_cyc, 2);

    // Abort owner 0 in WAIT; requester 1 follows
    clear_logs();
    period[31:0] = 32'd200; period[63:32] = 32'd20; req = 4'b0011;
    wait_ctl(50);
    chk("t4_owner", active_id, 0);
    repeat (10) step();
    req[0] = 1'b0; t = cyc;
    wait_done(1, 200, d);
    req = 4'b0000;
    stop_i = -1;
    for (int i = 0; i < wlog.size(); i++) if (stop_i < 0 && wlog[i].a == 1 && wlog[i].d == 8) stop_i = i;
    chk("t4_stop_seen", stop_i >= 0, 1);
    chk("t4_stop_cyc", wl_c(stop_i) - t, 1);
    chk("t4_clr_after_stop", wl_a(stop_i + 1), 0);
    chk("t4_clr_cyc", wl_c(stop_i + 1) - t, 2);
    chk("t4_done_count", didx.size(), 1);
    chk("t4_done_idx", (didx.size() > 0) ? didx[0] : -1, 1);

    // Zero period plus IRQ colliding with request drop
    clear_logs();
    auto_irq = 0;
    period[95:64] = 32'd0; req = 4'b0100;
    wait_ctl(50);
    repeat (3) step();
    tmr.tmr_irq = 1'b1; req = 4'b0000; irq_cyc = cyc;
    wait_done(2, 20, d);
    auto_irq = 1;
    chk("t5_pl_data", wl_d(0), 1);
    chk("t5_ph_data", wl_d(1), 0);
    chk("t5_irq_to_done", d - irq_cyc, 2);
    stop_i = -1;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i].a == 1 && wlog[i].d == 8) stop_i = i;
    chk("t5_no_stop", stop_i, -1);

    // Asynchronous reset while waiting
    period[63:32] = 32'd50; req = 4'b0010;
    wait_ctl(50);
    repeat (5) step();
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_owner", active_id, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cs", tmr.tmr_chipselect, 0);
    chk("t6_rst_write_n", tmr.tmr_write_n, 1);
    chk("t6_rst_addr", tmr.tmr_address, 0);
    chk("t6_rst_data", tmr.tmr_writedata, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_id", active_id, 0);
    step(); step();
    clear_logs();
    reset = 1'b0; t = cyc;
    wait_done(1, 200, d);
    req = 4'b0000;
    chk("t6_pl_addr", wl_a(0), 2);
    chk("t6_pl_data", wl_d(0), 50);
    chk("t6_pl_cyc", wl_c(0) - t, 2);
    chk("t6_done_cyc", d - t, 59);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nios_system_timer_sched.md
# nios_system_timer_sched

Hardware scheduler that time-shares the single Avalon interval timer (16-bit register map: status, control, period_l, period_h, snap_l, snap_h) among N_REQ one-shot timeout requesters. Round-robin arbitration selects a requester, then the block acts as the timer's only Avalon-MM master. It programs the period, starts the timer in one-shot mode with interrupt enabled, and waits for the timer IRQ. It then clears the timeout status and pulses `done` to the owning requester. It sits between the hardware clients and the timer slave, so software does not service per-client timeouts.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IDW, 2, width of `active_id` (clog2(N_REQ), minimum 1)
- clk  in  1  system clock, shared with the timer
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request per requester; held until `done`, or dropped to abort
- period  in  32*N_REQ  timeout length in clocks; requester i uses bits [32i+31:32i], sampled at grant
- done  out  N_REQ  one-cycle pulse when requester's timeout expires
- busy  out  1  high in every state except IDLE
- active_id  out  IDW  index of the current owner; valid while busy
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer chip select
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt

## Operation
- Reset values: done=0, busy=0, active_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, round-robin pointer=0, state=IDLE.
- All timer-bus outputs are registered. A write is a single cycle (chipselect=1, write_n=0); the timer has no waitrequest.
- States:
  - IDLE: if any req bit is set, go to GRANT.
  - GRANT: pick the first set req at or after the pointer, wrapping. Latch its index and period. If the latched period is 0, use 1. Go to WR_PL.
  - WR_PL: write addr 2 with period[15:0]. Go to WR_PH.
  - WR_PH: write addr 3 with period[31:16]. Go to GAP.
  - GAP: one idle cycle so the timer's force-reload completes before start. Go to WR_CTL.
  - WR_CTL: write addr 1 with 0x0005 (START, ITO, CONT=0). Go to WAIT.
  - WAIT: on tmr_irq=1, go to CLR. If req[owner]=0 and tmr_irq=0 (abort), go to STOP.
  - STOP: write addr 1 with 0x0008 (STOP, ITO=0). Go to CLR.
  - CLR: write addr 0 with 0x0000 to clear the timeout flag. If not aborted, go to DONE; else go to IDLE.
  - DONE: pulse done[owner]. Go to IDLE.
- Round-robin pointer becomes owner+1 (mod N_REQ) on leaving CLR, whether or not the timeout was aborted.
- Simultaneous tmr_irq and abort in WAIT: the IRQ wins; done is pulsed.
- Requests arriving while busy are held until IDLE; they are not lost.
- req changing for non-owners has no effect on the current transaction.
- tmr_irq is ignored outside WAIT.
- Reset mid-transaction returns to IDLE immediately and deasserts the timer bus. The timer is not stopped by this block; it has its own reset.

## Timing
- req set in IDLE → first timer write (WR_PL) on bus 2 cycles later (IDLE→GRANT→WR_PL).
- Grant to WR_CTL write: 4 cycles. A timer running P clocks raises IRQ roughly P+2 cycles after the WR_CTL write.
- tmr_irq high in WAIT → CLR write the next cycle → done pulse the cycle after.
- Minimum IDLE→IDLE turnaround, excluding WAIT: 8 cycles. Back-to-back grants insert exactly one IDLE cycle.

## Test plan
- Single request: req=4'b0001, period0=100. Expect writes addr2=100, addr3=0, a gap cycle, addr1=0x5; done[0] after tmr_irq; then addr0 write; busy low afterwards.
- Round-robin: req=4'b1011 held, all periods=20. Grant order 0,1,3,0; each done a single pulse; pointer wraps.
- Large period: period2=0x0001_86A0. Expect addr2=0x86A0, addr3=0x0001; done[2] only after IRQ.
- Abort: req0 dropped 10 cycles into WAIT. Expect addr1=0x8 then addr0 writes, no done[0], next requester granted.
- Zero period and IRQ/abort collision: period=0 gives addr2=1. tmr_irq rising in the same cycle req drops gives a done pulse.
- Reset asserted in WAIT: outputs return to reset values asynchronously; a fresh request after release restarts at WR_PL.
